// File: rtl/wb_stream_writer_dma.sv
// Wishbone B3 burst-read master that copies a (circular) memory buffer into a stream FIFO.
// Space for a whole burst is reserved before it starts, so the bus is never stalled mid-burst.
module wb_stream_writer_dma #(
  parameter int WB_AW         = 32,
  parameter int WB_DW         = 32,
  parameter int FIFO_AW       = 4,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  output logic [WB_AW-1:0]     wbm_adr_o,
  output logic [WB_DW-1:0]     wbm_dat_o,
  output logic [WB_DW/8-1:0]   wbm_sel_o,
  output logic                 wbm_we_o,
  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  output logic [2:0]           wbm_cti_o,
  output logic [1:0]           wbm_bte_o,
  input  logic [WB_DW-1:0]     wbm_dat_i,
  input  logic                 wbm_ack_i,
  input  logic                 wbm_err_i,
  input  logic                 wbm_rty_i,
  output logic [WB_DW-1:0]     fifo_d,
  output logic                 fifo_wr,
  input  logic [FIFO_AW:0]     fifo_cnt,
  input  logic                 enable,
  input  logic [WB_AW-1:0]     start_adr,
  input  logic [WB_AW-1:0]     buf_size,
  input  logic [WB_AW-1:0]     burst_size,
  input  logic                 continuous,
  output logic                 busy,
  output logic                 done_o,
  output logic                 err_o
);

  localparam int BYTES = WB_DW / 8;
  localparam int BSH   = $clog2(BYTES);
  localparam int CW    = ((WB_AW > FIFO_AW + 1) ? WB_AW : FIFO_AW + 1) + 1;
  localparam logic [CW-1:0]    DEPTH    = CW'(1'b1) << FIFO_AW;
  localparam logic [WB_AW-1:0] MAX_BLEN = WB_AW'(MAX_BURST_LEN);
  localparam logic [WB_AW-1:0] ONE      = {{(WB_AW-1){1'b0}}, 1'b1};
  localparam logic [WB_AW-1:0] ZERO     = {WB_AW{1'b0}};

  if (FIFO_AW <= 0) begin : g_bad_fifo_aw
    $error("FIFO_AW must be greater than zero");
  end
  if (MAX_BURST_LEN < 1 || MAX_BURST_LEN > (1 << FIFO_AW)) begin : g_bad_burst
    $error("MAX_BURST_LEN must lie in 1..2**FIFO_AW");
  end
  if (WB_DW < 8 || (WB_DW % 8) != 0 || (WB_DW & (WB_DW - 1)) != 0) begin : g_bad_dw
    $error("WB_DW must be a power of two and a multiple of 8");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_BURST = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WB_AW-1:0]   start_q, start_d;
  logic [WB_AW-1:0]   size_q, size_d;
  logic [WB_AW-1:0]   blen_q, blen_d;
  logic               cont_q, cont_d;
  logic [WB_AW-1:0]   words_q, words_d;
  logic [WB_AW-1:0]   beat_q, beat_d;
  logic               err_lock_q, err_lock_d;
  logic [WB_AW-1:0]   adr_q, adr_d;
  logic               cyc_q, cyc_d;
  logic [2:0]         cti_q, cti_d;
  logic [BYTES-1:0]   sel_q, sel_d;
  logic [WB_DW-1:0]   fifo_d_q, fifo_d_d;
  logic               fifo_wr_q, fifo_wr_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;

  logic [WB_AW-1:0]   blen_in_s;
  logic [WB_AW-1:0]   remain_s;
  logic [WB_AW-1:0]   len_s;
  logic [WB_AW-1:0]   beat_nxt_s;
  logic               fits_s;
  logic               last_beat_s;
  logic               pass_end_s;

  // Burst length clamping, remaining-length and FIFO-space arithmetic
  always_comb begin
    if (burst_size == ZERO) begin
      blen_in_s = ONE;
    end else if (burst_size > MAX_BLEN) begin
      blen_in_s = MAX_BLEN;
    end else begin
      blen_in_s = burst_size;
    end
    remain_s    = size_q - words_q;
    len_s       = (blen_q < remain_s) ? blen_q : remain_s;
    beat_nxt_s  = beat_q + ONE;
    // Widened compare: a full FIFO plus a long burst cannot wrap
    fits_s      = ({{(CW-FIFO_AW-1){1'b0}}, fifo_cnt} + {{(CW-WB_AW){1'b0}}, len_s}) <= DEPTH;
    last_beat_s = (beat_nxt_s == len_s);
    pass_end_s  = ((words_q + len_s) == size_q);
  end

  // Next-state and output decode
  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    size_d     = size_q;
    blen_d     = blen_q;
    cont_d     = cont_q;
    words_d    = words_q;
    beat_d     = beat_q;
    adr_d      = adr_q;
    cyc_d      = cyc_q;
    cti_d      = cti_q;
    sel_d      = sel_q;
    fifo_d_d   = fifo_d_q;
    fifo_wr_d  = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    // After a bus error, a fresh run needs enable to drop first
    if (!enable) begin
      err_lock_d = 1'b0;
    end else begin
      err_lock_d = err_lock_q;
    end

    case (state_q)
      S_IDLE: begin
        if (enable && (buf_size != ZERO) && !err_lock_q) begin
          start_d = start_adr;
          size_d  = buf_size;
          blen_d  = blen_in_s;
          cont_d  = continuous;
          words_d = ZERO;
          beat_d  = ZERO;
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_WAIT: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (fits_s) begin
          state_d = S_BURST;
          cyc_d   = 1'b1;
          sel_d   = {BYTES{1'b1}};
          beat_d  = ZERO;
          adr_d   = start_q + (words_q << BSH);
          cti_d   = (len_s == ONE) ? 3'b111 : 3'b010;
        end else begin
          state_d = S_WAIT;
        end
      end

      S_BURST: begin
        if (wbm_err_i) begin
          cyc_d      = 1'b0;
          sel_d      = {BYTES{1'b0}};
          cti_d      = 3'b000;
          beat_d     = ZERO;
          err_d      = 1'b1;
          err_lock_d = 1'b1;
          state_d    = S_IDLE;
        end else if (wbm_rty_i) begin
          // Keep what was acked; the rest is re-requested as a new burst
          cyc_d   = 1'b0;
          sel_d   = {BYTES{1'b0}};
          cti_d   = 3'b000;
          words_d = words_q + beat_q;
          beat_d  = ZERO;
          state_d = S_WAIT;
        end else if (wbm_ack_i) begin
          fifo_wr_d = 1'b1;
          fifo_d_d  = wbm_dat_i;
          if (last_beat_s) begin
            cyc_d   = 1'b0;
            sel_d   = {BYTES{1'b0}};
            cti_d   = 3'b000;
            beat_d  = ZERO;
            words_d = words_q + len_s;
            if (pass_end_s) begin
              done_d = 1'b1;
              if (cont_q && enable) begin
                words_d = ZERO;
                state_d = S_WAIT;
              end else begin
                state_d = S_IDLE;
              end
            end else if (enable) begin
              state_d = S_WAIT;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            beat_d = beat_nxt_s;
            adr_d  = start_q + ((words_q + beat_nxt_s) << BSH);
            cti_d  = ((beat_nxt_s + ONE) == len_s) ? 3'b111 : 3'b010;
          end
        end else begin
          state_d = S_BURST;
        end
      end

      default: begin
        state_d = S_IDLE;
        cyc_d   = 1'b0;
        sel_d   = {BYTES{1'b0}};
        cti_d   = 3'b000;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= S_IDLE;
      start_q    <= ZERO;
      size_q     <= ZERO;
      blen_q     <= ZERO;
      cont_q     <= 1'b0;
      words_q    <= ZERO;
      beat_q     <= ZERO;
      err_lock_q <= 1'b0;
      adr_q      <= ZERO;
      cyc_q      <= 1'b0;
      cti_q      <= 3'b000;
      sel_q      <= {BYTES{1'b0}};
      fifo_d_q   <= {WB_DW{1'b0}};
      fifo_wr_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      size_q     <= size_d;
      blen_q     <= blen_d;
      cont_q     <= cont_d;
      words_q    <= words_d;
      beat_q     <= beat_d;
      err_lock_q <= err_lock_d;
      adr_q      <= adr_d;
      cyc_q      <= cyc_d;
      cti_q      <= cti_d;
      sel_q      <= sel_d;
      fifo_d_q   <= fifo_d_d;
      fifo_wr_q  <= fifo_wr_d;
      done_q     <= done_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = {WB_DW{1'b0}};
  assign wbm_sel_o = sel_q;
  assign wbm_we_o  = 1'b0;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_cti_o = cti_q;
  assign wbm_bte_o = 2'b00;
  assign fifo_d    = fifo_d_q;
  assign fifo_wr   = fifo_wr_q;
  assign busy      = busy_q;
  assign done_o    = done_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_wb_stream_writer_dma.sv
// Scoreboard bench: expected bus beats and FIFO words are queued per scenario and
// popped by a negedge monitor; a second 64-bit instance covers address stepping.
module tb_wb_stream_writer_dma;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam logic [31:0] DMASK = 32'h5A5A_0000;

  logic wb_clk = 1'b0;
  logic wb_rst = 1'b1;

  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i, fifo_d;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_ack_i, wbm_err_i, wbm_rty_i;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic        fifo_wr, busy, done_o, err_o;
  logic [3:0]  fifo_cnt = 4'd0;
  logic        enable = 1'b0, continuous = 1'b0;
  logic [31:0] start_adr = 32'd0, buf_size = 32'd0, burst_size = 32'd0;

  logic [31:0] adr_b;
  logic [63:0] dat_o_b, dat_i_b, fifo_d_b;
  logic [7:0]  sel_b;
  logic        we_b, cyc_b, stb_b, ack_b, fifo_wr_b, busy_b, done_b, err_b;
  logic [2:0]  cti_b;
  logic [1:0]  bte_b;
  logic        enable_b = 1'b0;
  logic [31:0] start_b = 32'd0, size_b = 32'd0, bsz_b = 32'd0;

  int burst_no = 0, slv_beat = 0;
  int err_burst = -1, err_beat = 0, rty_burst = -1, rty_beat = 0;
  int n_cmp = 0, n_bad = 0, n_done = 0, n_err = 0;
  logic [34:0] beat_q[$];
  logic [31:0] data_q[$];

  always #5 wb_clk = ~wb_clk;

  wb_stream_writer_dma #(.WB_AW(32), .WB_DW(32), .FIFO_AW(3), .MAX_BURST_LEN(8)) dut (
    .wb_clk_i(wb_clk), .wb_rst_i(wb_rst),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o), .wbm_we_o(wbm_we_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i),
    .fifo_d(fifo_d), .fifo_wr(fifo_wr), .fifo_cnt(fifo_cnt), .enable(enable),
    .start_adr(start_adr), .buf_size(buf_size), .burst_size(burst_size), .continuous(continuous),
    .busy(busy), .done_o(done_o), .err_o(err_o));

  wb_stream_writer_dma #(.WB_AW(32), .WB_DW(64), .FIFO_AW(4), .MAX_BURST_LEN(16)) dut_b (
    .wb_clk_i(wb_clk), .wb_rst_i(wb_rst),
    .wbm_adr_o(adr_b), .wbm_dat_o(dat_o_b), .wbm_sel_o(sel_b), .wbm_we_o(we_b),
    .wbm_cyc_o(cyc_b), .wbm_stb_o(stb_b), .wbm_cti_o(cti_b), .wbm_bte_o(bte_b),
    .wbm_dat_i(dat_i_b), .wbm_ack_i(ack_b), .wbm_err_i(1'b0), .wbm_rty_i(1'b0),
    .fifo_d(fifo_d_b), .fifo_wr(fifo_wr_b), .fifo_cnt(5'd0), .enable(enable_b),
    .start_adr(start_b), .buf_size(size_b), .burst_size(bsz_b), .continuous(1'b0),
    .busy(busy_b), .done_o(done_b), .err_o(err_b));

  // Zero-wait slave with one-shot err/rty injection on a chosen burst and beat
  assign wbm_ack_i = wbm_cyc_o && wbm_stb_o;
  assign wbm_err_i = wbm_cyc_o && wbm_stb_o && (burst_no == err_burst) && (slv_beat == err_beat);
  assign wbm_rty_i = wbm_cyc_o && wbm_stb_o && (burst_no == rty_burst) && (slv_beat == rty_beat);
  assign wbm_dat_i = wbm_adr_o ^ DMASK;
  assign ack_b     = cyc_b && stb_b;
  assign dat_i_b   = {adr_b, ~adr_b};

  always @(posedge wb_clk) begin
    if (!wbm_cyc_o) slv_beat <= 0;
    else if (wbm_ack_i || wbm_err_i || wbm_rty_i) slv_beat <= slv_beat + 1;
    if (wbm_cyc_o && (wbm_err_i || wbm_rty_i || (wbm_ack_i && wbm_cti_o == 3'b111)))
      burst_no <= burst_no + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_beats(input int w0, input int n, input int len);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      logic [2:0]  c;
      a = BASE + 32'(4 * (w0 + i));
      c = (i == len - 1) ? 3'b111 : 3'b010;
      beat_q.push_back({c, a});
    end
  endtask

  task automatic push_data(input int w0, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      a = BASE + 32'(4 * (w0 + i));
      data_q.push_back(a ^ DMASK);
    end
  endtask

  task automatic monitor();
    logic [34:0] eb;
    logic [31:0] ed;
    forever begin
      @(negedge wb_clk);
      if (wbm_cyc_o && wbm_stb_o && (wbm_ack_i || wbm_err_i || wbm_rty_i)) begin
        if (beat_q.size() == 0) begin
          chk("beat_unexpected", 64'(beat_q.size()), 64'd1);
        end else begin
          eb = beat_q.pop_front();
          chk("beat_adr", 64'(wbm_adr_o), 64'(eb[31:0]));
          chk("beat_cti", 64'(wbm_cti_o), 64'(eb[34:32]));
          chk("beat_sel", 64'(wbm_sel_o), 64'hF);
        end
      end
      if (fifo_wr) begin
        if (data_q.size() == 0) begin
          chk("fifo_wr_unexpected", 64'(data_q.size()), 64'd1);
        end else begin
          ed = data_q.pop_front();
          chk("fifo_data", 64'(fifo_d), 64'(ed));
        end
      end
      if (done_o) n_done++;
      if (err_o) n_err++;
    end
  endtask

  task automatic run(input int size, input int bsz, input logic cont);
    start_adr  = BASE;
    buf_size   = 32'(size);
    burst_size = 32'(bsz);
    continuous = cont;
    enable     = 1'b1;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    do begin @(negedge wb_clk); k++; end while (!done_o && k < 400);
    chk(tag, 64'(done_o), 64'd1);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    do begin @(negedge wb_clk); k++; end while (busy && k < 200);
    chk(tag, 64'(busy), 64'd0);
  endtask

  task automatic finish_test(input string tag);
    @(negedge wb_clk);
    chk({tag, "_beats_left"}, 64'(beat_q.size()), 64'd0);
    chk({tag, "_data_left"}, 64'(data_q.size()), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done_pulse"}, 64'(done_o), 64'd0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_cyc"}, 64'(wbm_cyc_o), 64'd0);
    chk({tag, "_stb"}, 64'(wbm_stb_o), 64'd0);
    chk({tag, "_adr"}, 64'(wbm_adr_o), 64'd0);
    chk({tag, "_sel"}, 64'(wbm_sel_o), 64'd0);
    chk({tag, "_cti"}, 64'(wbm_cti_o), 64'd0);
    chk({tag, "_fifo_wr"}, 64'(fifo_wr), 64'd0);
    chk({tag, "_fifo_d"}, 64'(fifo_d), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done_o), 64'd0);
    chk({tag, "_err"}, 64'(err_o), 64'd0);
  endtask

  initial begin
    int nd, ne, k;
    fork
      monitor();
    join_none

    repeat (3) @(negedge wb_clk);
    chk_quiet("rst");
    chk("rst_dat_o", 64'(wbm_dat_o), 64'd0);
    chk("rst_we", 64'(wbm_we_o), 64'd0);
    chk("rst_bte", 64'(wbm_bte_o), 64'd0);
    wb_rst = 1'b0;
    @(negedge wb_clk);
    chk("idle_busy", 64'(busy), 64'd0);

    // Basic one-shot pass: two full bursts
    nd = n_done;
    push_beats(0, 4, 4); push_beats(4, 4, 4); push_data(0, 8);
    run(8, 4, 1'b0);
    wait_done("basic_done");
    enable = 1'b0;
    finish_test("basic");
    chk("basic_done_cnt", 64'(n_done - nd), 64'd1);

    // Partial final burst 4,4,2
    nd = n_done;
    push_beats(0, 4, 4); push_beats(4, 4, 4); push_beats(8, 2, 2); push_data(0, 10);
    run(10, 4, 1'b0);
    wait_done("partial_done");
    enable = 1'b0;
    finish_test("partial");
    chk("partial_done_cnt", 64'(n_done - nd), 64'd1);

    // Burst size above the maximum clamps to 8
    push_beats(0, 8, 8); push_beats(8, 2, 2); push_data(0, 10);
    run(10, 20, 1'b0);
    wait_done("clamp_done");
    enable = 1'b0;
    finish_test("clamp");

    // Continuous wrap: two full passes, then drop enable inside the third pass
    nd = n_done;
    for (int p = 0; p < 2; p++) begin
      push_beats(0, 4, 4); push_beats(4, 2, 2); push_data(0, 6);
    end
    push_beats(0, 4, 4); push_data(0, 4);
    run(6, 4, 1'b1);
    wait_done("cont_done1");
    wait_done("cont_done2");
    repeat (2) @(negedge wb_clk);
    enable = 1'b0;
    wait_idle("cont_idle");
    finish_test("cont");
    chk("cont_done_cnt", 64'(n_done - nd), 64'd2);
    continuous = 1'b0;

    // FIFO backpressure with depth 8
    fifo_cnt = 4'd5;
    push_beats(0, 4, 4); push_data(0, 4);
    run(4, 4, 1'b0);
    repeat (10) @(negedge wb_clk);
    chk("bp_wait_busy", 64'(busy), 64'd1);
    chk("bp_wait_cyc", 64'(wbm_cyc_o), 64'd0);
    fifo_cnt = 4'd4;
    @(negedge wb_clk);
    chk("bp_start_cyc", 64'(wbm_cyc_o), 64'd1);
    wait_done("bp_done");
    enable = 1'b0;
    fifo_cnt = 4'd0;
    finish_test("bp");

    // Bus error on beat 2, then enable edge required to restart
    ne = n_err;
    err_burst = burst_no; err_beat = 2;
    push_beats(0, 3, 4); push_data(0, 2);
    run(8, 4, 1'b0);
    k = 0;
    do begin @(negedge wb_clk); k++; end while (!err_o && k < 100);
    chk("err_seen", 64'(err_o), 64'd1);
    chk("err_no_cyc", 64'(wbm_cyc_o), 64'd0);
    err_burst = -1;
    @(negedge wb_clk);
    chk("err_pulse", 64'(err_o), 64'd0);
    repeat (5) @(negedge wb_clk);
    chk("err_locked_busy", 64'(busy), 64'd0);
    chk("err_locked_cyc", 64'(wbm_cyc_o), 64'd0);
    chk("err_cnt", 64'(n_err - ne), 64'd1);
    chk("err_beats_left", 64'(beat_q.size()), 64'd0);
    enable = 1'b0;
    @(negedge wb_clk);
    push_beats(0, 4, 4); push_beats(4, 4, 4); push_data(0, 8);
    enable = 1'b1;
    wait_done("err_restart_done");
    enable = 1'b0;
    finish_test("err_restart");

    // Retry on beat 1 of 4: resume at word 1 with len 3
    rty_burst = burst_no; rty_beat = 1;
    push_beats(0, 2, 4); push_beats(1, 3, 3); push_data(0, 4);
    run(4, 4, 1'b0);
    wait_done("rty_done");
    enable = 1'b0;
    rty_burst = -1;
    finish_test("rty");

    // Reset in the middle of a burst
    push_beats(0, 2, 4); push_data(0, 1);
    run(8, 4, 1'b0);
    k = 0;
    do begin @(negedge wb_clk); k++; end while (!wbm_cyc_o && k < 20);
    chk("mrst_cyc_up", 64'(wbm_cyc_o), 64'd1);
    @(negedge wb_clk);
    wb_rst = 1'b1;
    enable = 1'b0;
    @(negedge wb_clk);
    chk_quiet("mrst");
    wb_rst = 1'b0;
    finish_test("mrst");

    // 64-bit instance: 8-byte stepping and full byte selects
    start_b = 32'h0000_2000; size_b = 32'd2; bsz_b = 32'd2; enable_b = 1'b1;
    k = 0;
    do begin @(negedge wb_clk); k++; end while (!cyc_b && k < 20);
    chk("w64_cyc", 64'(cyc_b), 64'd1);
    chk("w64_adr0", 64'(adr_b), 64'h2000);
    chk("w64_sel", 64'(sel_b), 64'hFF);
    chk("w64_cti0", 64'(cti_b), 64'd2);
    @(negedge wb_clk);
    chk("w64_adr1", 64'(adr_b), 64'h2008);
    chk("w64_cti1", 64'(cti_b), 64'd7);
    chk("w64_wr0", 64'(fifo_wr_b), 64'd1);
    chk("w64_d0", fifo_d_b, 64'h0000_2000_FFFF_DFFF);
    @(negedge wb_clk);
    enable_b = 1'b0;
    chk("w64_wr1", 64'(fifo_wr_b), 64'd1);
    chk("w64_d1", fifo_d_b, 64'h0000_2008_FFFF_DFF7);
    chk("w64_done", 64'(done_b), 64'd1);
    chk("w64_cyc_down", 64'(cyc_b), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
